// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures FU results into per-entry
// CDB slots, acknowledges each capture on reset_bus and retires entries in program order.
module reorder_buffer #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 3,
    parameter int FU_NUM    = 4,
    parameter int REG_INDEX = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          issue_valid,
    input  logic [REG_INDEX-1:0]          issue_dest_reg,
    output logic                          issue_ready,
    output logic [RB_INDEX-1:0]           issue_index,
    input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
    input  logic [FU_NUM-1:0]             valid_bus,
    input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
    output logic [FU_NUM-1:0]             reset_bus,
    output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    output logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic                          commit_valid,
    output logic [REG_INDEX-1:0]          commit_reg,
    output logic [WORD_SIZE-1:0]          commit_data,
    output logic [RB_INDEX-1:0]           commit_index
);

    localparam logic [RB_INDEX:0] FULL_COUNT = (RB_INDEX+1)'(RB_SIZE);

    // Per-entry lifecycle; entry_state is the observable state vector of the buffer.
    typedef enum logic [1:0] {
        ENT_FREE    = 2'd0,
        ENT_PENDING = 2'd1,
        ENT_DONE    = 2'd2
    } entry_state_t;

    entry_state_t         entry_state [RB_SIZE];
    logic [REG_INDEX-1:0] entry_reg   [RB_SIZE];
    logic [WORD_SIZE-1:0] entry_data  [RB_SIZE];

    logic [RB_INDEX-1:0]  head;
    logic [RB_INDEX-1:0]  tail;
    logic [RB_INDEX:0]    count;

    logic [WORD_SIZE-1:0] fu_data [FU_NUM];
    logic [RB_INDEX-1:0]  fu_tag  [FU_NUM];
    logic [FU_NUM-1:0]    grant;
    logic [RB_SIZE-1:0]   cap;
    logic [WORD_SIZE-1:0] cap_data [RB_SIZE];

    logic do_issue;
    logic do_commit;

    assign issue_ready = (count < FULL_COUNT);
    assign issue_index = tail;
    assign do_issue    = issue_valid && issue_ready;
    assign do_commit   = (entry_state[head] == ENT_DONE);

    always_comb begin
        for (int f = 0; f < FU_NUM; f++) begin
            fu_data[f] = data_bus[f*WORD_SIZE +: WORD_SIZE];
            fu_tag[f]  = RB_index_bus[f*RB_INDEX +: RB_INDEX];
        end
    end

    // A lower-numbered FU aiming at the same tag always wins; the loser gets no ack and retries.
    always_comb begin
        for (int f = 0; f < FU_NUM; f++) begin
            grant[f] = valid_bus[f] && (entry_state[fu_tag[f]] == ENT_PENDING);
            for (int g = 0; g < FU_NUM; g++) begin
                if (g < f && valid_bus[g] && fu_tag[g] == fu_tag[f]) begin
                    grant[f] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cap = '0;
        for (int i = 0; i < RB_SIZE; i++) begin
            cap_data[i] = '0;
            for (int f = 0; f < FU_NUM; f++) begin
                if (grant[f] && fu_tag[f] == RB_INDEX'(i)) begin
                    cap[i]      = 1'b1;
                    cap_data[i] = fu_data[f];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RB_SIZE; i++) begin
            CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = entry_data[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RB_SIZE; i++) begin
                entry_state[i] <= ENT_FREE;
                entry_reg[i]   <= '0;
                entry_data[i]  <= '0;
            end
            CDB_data_valid <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            reset_bus      <= '0;
            commit_valid   <= 1'b0;
            commit_reg     <= '0;
            commit_data    <= '0;
            commit_index   <= '0;
        end else begin
            reset_bus    <= grant;
            commit_valid <= do_commit;
            if (do_commit) begin
                commit_reg   <= entry_reg[head];
                commit_data  <= entry_data[head];
                commit_index <= head;
            end

            // Commit, issue and capture never touch the same slot in one cycle:
            // the head is DONE when committing, the tail is FREE when issuing.
            for (int i = 0; i < RB_SIZE; i++) begin
                if (do_commit && head == RB_INDEX'(i)) begin
                    entry_state[i]    <= ENT_FREE;
                    CDB_data_valid[i] <= 1'b0;
                end else if (do_issue && tail == RB_INDEX'(i)) begin
                    entry_state[i]    <= ENT_PENDING;
                    entry_reg[i]      <= issue_dest_reg;
                    CDB_data_valid[i] <= 1'b0;
                end else if (cap[i]) begin
                    entry_state[i]    <= ENT_DONE;
                    entry_data[i]     <= cap_data[i];
                    CDB_data_valid[i] <= 1'b1;
                end
            end

            if (do_issue) begin
                tail <= tail + 1'b1;
            end
            if (do_commit) begin
                head <= head + 1'b1;
            end
            count <= count + (RB_INDEX+1)'(do_issue) - (RB_INDEX+1)'(do_commit);
        end
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer directly downstream of the reservation stations (load RS, ALU RS).
- Allocates a tag at issue and captures FU results from the shared FU result buses.
- Acknowledges each capture by pulsing that FU's reset line, publishes completed entries on the CDB data bus, and retires entries in program order to the register file.

Parameters:
- WORD_SIZE, 32, data width.
- RB_SIZE, 8, number of entries (power of two, ≥2).
- RB_INDEX, 3, tag width, log2(RB_SIZE).
- FU_NUM, 4, number of functional units on the result buses.
- REG_INDEX, 5, architectural register index width.

Ports:
- clk  in  1  clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  allocate request from issue stage.
- issue_dest_reg  in  REG_INDEX  destination register of the issued instruction.
- issue_ready  out  1  entry available (count < RB_SIZE).
- issue_index  out  RB_INDEX  tag that will be allocated (tail pointer).
- data_bus  in  FU_NUM*WORD_SIZE  FU results, slice f = FU f.
- valid_bus  in  FU_NUM  FU result valid.
- RB_index_bus  in  FU_NUM*RB_INDEX  FU result destination tag.
- reset_bus  out  FU_NUM  per-FU capture acknowledge / FU clear.
- CDB_data_data  out  WORD_SIZE*RB_SIZE  per-entry result, slice i = entry i.
- CDB_data_valid  out  RB_SIZE  entry i result is valid.
- commit_valid  out  1  retire pulse.
- commit_reg  out  REG_INDEX  retired destination register.
- commit_data  out  WORD_SIZE  retired value.
- commit_index  out  RB_INDEX  retired tag.

Behaviour:
- Entry state per slot is FREE, PENDING or DONE. Pointers are head, tail (RB_INDEX bits, wrap mod RB_SIZE) and count (RB_INDEX+1 bits).
- Reset (reset_n low, async):
  - All entries FREE; head = tail = count = 0.
  - issue_ready = 1, issue_index = 0.
  - reset_bus, CDB_data_valid, CDB_data_data, commit_* all 0.
- issue_ready and issue_index are combinational from the registered count and tail only, with no same-cycle commit bypass.
- Issue: at a posedge with issue_valid && issue_ready:
  - entry[tail] becomes PENDING with reg = issue_dest_reg.
  - CDB_data_valid[tail] is cleared; tail increments.
  - issue_valid while full is ignored with no state change.
- Writeback: at each posedge, for every f with valid_bus[f] == 1 and entry[RB_index_bus slice f] PENDING:
  - capture data into CDB_data_data slice; entry becomes DONE; CDB_data_valid bit set (visible after this edge).
  - reset_bus[f] is high for exactly the following cycle.
  - All FU_NUM ports may capture in the same cycle.
- Writeback conflicts:
  - Two FUs targeting the same PENDING tag in one cycle: lowest f is captured and acked; the others get no ack and retry.
  - valid_bus[f] to a FREE or DONE entry: ignored, no ack.
  - valid held high across the ack cycle is not recaptured, because the entry is no longer PENDING.
- Commit: at a posedge where entry[head] is DONE (state registered before this edge):
  - commit_valid = 1 for one cycle, with commit_reg/data/index from head.
  - entry becomes FREE; CDB_data_valid[head] cleared; head increments.
  - At most one commit per cycle. Otherwise commit_valid = 0 and the other commit_* hold their last values.
- Latency: a result captured at edge k is on the CDB from edge k; the earliest commit_valid is at edge k+1.
- Simultaneous events:
  - Issue and commit in the same cycle: count unchanged, both occur.
  - Full with commit: issue still rejected that cycle.
  - Writeback to head in the same cycle as a commit check: commit waits one cycle.
- Reset mid-operation: all in-flight entries are discarded and no commit pulse is produced; reset_bus goes low immediately.

Test Plan:
- Reset then idle → issue_ready = 1, issue_index = 0, commit_valid = 0, CDB_data_valid = 8'h00.
- Issue r3 (tag 0); FU1 returns 32'h0000_00AA for tag 0 two cycles later → reset_bus = 4'b0010 for one cycle; CDB_data_valid[0] = 1; next edge commit_valid = 1, commit_reg = 3, commit_data = 32'hAA, commit_index = 0.
- Issue tags 0,1,2; results arrive for 2, 1, then 0 → no commit until tag 0 is DONE, then commits 0, 1, 2 on consecutive cycles.
- Issue 8 without writeback → issue_ready = 0 after the 8th; 9th issue_valid ignored, tail = 0; one writeback plus commit of tag 0 → issue_ready = 1, issue_index = 0 (wrap).
- FU0 and FU2 both valid for pending tag 4 → only FU0 captured, reset_bus = 4'b0001; FU0 and FU3 for distinct tags 5, 6 → reset_bus = 4'b1001.
- Assert reset_n low with 3 entries PENDING/DONE → all outputs 0 immediately; after release, issue_index = 0 and no stray commit_valid.
